// File: rtl/ma_stage.sv
// Memory-access stage: issues loads/stores on the dmem req/ready port and
// registers results (PC, instruction, ALU result, load data, fault flags) for write-back.
//
// Handshake: dmem_req rises together with stable dmem_we/addr/wdata/wstrb and
// stays high, unchanged, until a posedge samples dmem_ready=1 (transfer done,
// dmem_rdata captured on that same edge). If TIMEOUT cycles pass first, the
// access is abandoned and flagged as a bus error. Towards EX, MA_busy=1 means
// "not ready": EX must hold its output registers on that edge.
module ma_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] EX_PC,
  input  logic [31:0] EX_instruction,
  input  logic [31:0] EX_aluresult,
  input  logic [31:0] EX_op2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MA_busy,
  output logic [31:0] MA_PC,
  output logic [31:0] MA_instruction,
  output logic [31:0] MA_aluresult,
  output logic [31:0] MA_ldresult,
  output logic        MA_misaligned,
  output logic        MA_bus_error,
  output logic [1:0]  ma_state
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] counter;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_lo;
  logic [31:0]   cap_ld;
  logic          cap_err;

  logic [2:0]  funct3;
  logic        is_load, is_store, misaligned, aligned_mem;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        start, finish_ok, timeout, pass, retire;

  assign funct3   = EX_instruction[14:12];
  assign is_load  = (EX_instruction[6:0] == OP_LOAD);
  assign is_store = (EX_instruction[6:0] == OP_STORE);
  assign ma_state = state;

  // Decode the EX instruction: alignment check and store lane formatting.
  always_comb begin
    misaligned  = (is_load | is_store) &
                  (((funct3[1:0] == 2'b01) & EX_aluresult[0]) |
                   ((funct3[1:0] == 2'b10) & (EX_aluresult[1:0] != 2'b00)));
    aligned_mem = (is_load | is_store) & ~misaligned;
    st_wdata    = EX_op2;
    st_wstrb    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{EX_op2[7:0]}};
        st_wstrb = 4'b0001 << EX_aluresult[1:0];
      end
      2'b01: begin
        st_wdata = {2{EX_op2[15:0]}};
        st_wstrb = 4'b0011 << EX_aluresult[1:0];
      end
      default: begin
        st_wdata = EX_op2;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Extract and extend the load lane selected by the latched address/width.
  always_comb begin
    ld_byte = 8'h00;
    case (lat_lo)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lat_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = dmem_rdata;
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = 32'h0;
    endcase
  end

  // Next-state logic and one-cycle action strobes for the register blocks.
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    finish_ok = 1'b0;
    timeout   = 1'b0;
    pass      = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE: if (!stall) begin
        if (aligned_mem) begin
          start    = 1'b1;
          state_nx = S_WAIT;
        end else begin
          pass = 1'b1;
        end
      end
      S_WAIT: if (dmem_ready) begin
        finish_ok = 1'b1;
        state_nx  = S_DONE;
      end else if (counter == LAST) begin
        timeout  = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: if (!stall) begin
        retire   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A DONE op also holds EX, except that EX advances on the edge MA retires it.
  assign MA_busy = stall | ((state == S_IDLE) & aligned_mem) | (state == S_WAIT);

  // State register and WAIT-cycle counter.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state   <= S_IDLE;
      counter <= '0;
    end else begin
      state <= state_nx;
      if (start || retire) counter <= '0;
      else if (state == S_WAIT) counter <= counter + 1'b1;
    end
  end

  // Data-memory port registers and captured completion results.
  always_ff @(posedge clk1) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_wstrb <= 4'h0;
      lat_f3     <= 3'h0;
      lat_lo     <= 2'h0;
      cap_ld     <= 32'h0;
      cap_err    <= 1'b0;
    end else begin
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {EX_aluresult[31:2], 2'b00};
        dmem_wdata <= is_store ? st_wdata : 32'h0;
        dmem_wstrb <= is_store ? st_wstrb : 4'h0;
        lat_f3     <= funct3;
        lat_lo     <= EX_aluresult[1:0];
        cap_ld     <= 32'h0;
        cap_err    <= 1'b0;
      end
      if (finish_ok) begin
        dmem_req <= 1'b0;
        cap_ld   <= dmem_we ? 32'h0 : ld_ext;
        cap_err  <= 1'b0;
      end
      if (timeout) begin
        dmem_req <= 1'b0;
        cap_ld   <= 32'h0;
        cap_err  <= 1'b1;
      end
    end
  end

  // Write-back registers: pass-through in IDLE, completed memory op from DONE.
  always_ff @(posedge clk1) begin
    if (rst) begin
      MA_PC          <= 32'h0;
      MA_instruction <= NOP;
      MA_aluresult   <= 32'h0;
      MA_ldresult    <= 32'h0;
      MA_misaligned  <= 1'b0;
      MA_bus_error   <= 1'b0;
    end else if (pass || retire) begin
      MA_PC          <= EX_PC;
      MA_instruction <= EX_instruction;
      MA_aluresult   <= EX_aluresult;
      MA_ldresult    <= retire ? cap_ld : 32'h0;
      MA_misaligned  <= pass & misaligned;
      MA_bus_error   <= retire & cap_err;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: vector table for single ops, plus sequences
// for late ready, timeout, reset during an access and downstream stall.
module tb_ma_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk1 = 1'b0;
  logic        rst, stall;
  logic [31:0] EX_PC, EX_instruction, EX_aluresult, EX_op2;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        MA_busy, MA_misaligned, MA_bus_error;
  logic [31:0] MA_PC, MA_instruction, MA_aluresult, MA_ldresult;
  logic [1:0]  ma_state;

  int n_cmp = 0;
  int n_err = 0;

  ma_stage #(.TIMEOUT(16)) dut (
    .clk1(clk1), .rst(rst), .stall(stall),
    .EX_PC(EX_PC), .EX_instruction(EX_instruction),
    .EX_aluresult(EX_aluresult), .EX_op2(EX_op2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .MA_busy(MA_busy), .MA_PC(MA_PC), .MA_instruction(MA_instruction),
    .MA_aluresult(MA_aluresult), .MA_ldresult(MA_ldresult),
    .MA_misaligned(MA_misaligned), .MA_bus_error(MA_bus_error),
    .ma_state(ma_state)
  );

  // Clock.
  always #5 clk1 = ~clk1;

  typedef struct {
    logic [31:0] instr, pc, alu, op2, rdata;
    logic        mem;
    logic        mis;
    logic [31:0] ld;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata, addr;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] mk_ld(input logic [2:0] f3);
    return {12'h000, 5'd1, f3, 5'd2, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_st(input logic [2:0] f3);
    return {7'h00, 5'd3, 5'd1, f3, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] mk_addi(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd2, 7'b0010011};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, pc, alu, op2, rdata,
                               input logic mem, mis, input logic [31:0] ld,
                               input logic we, input logic [3:0] strb,
                               input logic [31:0] wdata, addr);
    vec_t v;
    v.instr = instr; v.pc = pc; v.alu = alu; v.op2 = op2; v.rdata = rdata;
    v.mem = mem; v.mis = mis; v.ld = ld; v.we = we; v.strb = strb;
    v.wdata = wdata; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic [31:0] instr, pc, alu, op2);
    EX_instruction = instr;
    EX_PC          = pc;
    EX_aluresult   = alu;
    EX_op2         = op2;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  logic [31:0] prev_pc;
  int busy_cnt, wait_n, req_cnt;

  initial begin
    // Reset with a nop in EX.
    rst = 1'b1; stall = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    drive_ex(NOP, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_MA_instruction", MA_instruction, NOP);
    chk("rst_MA_PC", MA_PC, 32'h0);
    chk("rst_MA_ldresult", MA_ldresult, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_dmem_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_state", {30'h0, ma_state}, 32'h0);
    chk("rst_busy", {31'h0, MA_busy}, 32'h0);

    //             instr          pc            alu           op2           rdata       mem mis ld            we strb     wdata         addr
    vecs[0]  = mkv(mk_addi(12'd5), 32'h100, 32'h0000_0005, 32'h0,         32'h0,         0, 0, 32'h0,         0, 4'h0,    32'h0,        32'h0);
    vecs[1]  = mkv(mk_ld(3'b010), 32'h104, 32'h0000_0001, 32'h0,         32'h0,         0, 1, 32'h0,         0, 4'h0,    32'h0,        32'h0);
    vecs[2]  = mkv(mk_ld(3'b001), 32'h108, 32'h0000_0003, 32'h0,         32'h0,         0, 1, 32'h0,         0, 4'h0,    32'h0,        32'h0);
    vecs[3]  = mkv(mk_st(3'b010), 32'h10C, 32'h0000_0102, 32'h1111_2222, 32'h0,         0, 1, 32'h0,         0, 4'h0,    32'h0,        32'h0);
    vecs[4]  = mkv(mk_ld(3'b000), 32'h110, 32'h0000_1003, 32'h0,         32'h80FF_FF7F, 1, 0, 32'hFFFF_FF80, 0, 4'h0,    32'h0,        32'h0000_1000);
    vecs[5]  = mkv(mk_ld(3'b100), 32'h114, 32'h0000_1001, 32'h0,         32'h80FF_FF7F, 1, 0, 32'h0000_00FF, 0, 4'h0,    32'h0,        32'h0000_1000);
    vecs[6]  = mkv(mk_ld(3'b001), 32'h118, 32'h0000_1002, 32'h0,         32'h80FF_FF7F, 1, 0, 32'hFFFF_80FF, 0, 4'h0,    32'h0,        32'h0000_1000);
    vecs[7]  = mkv(mk_ld(3'b101), 32'h11C, 32'h0000_1000, 32'h0,         32'h80FF_FF7F, 1, 0, 32'h0000_FF7F, 0, 4'h0,    32'h0,        32'h0000_1000);
    vecs[8]  = mkv(mk_ld(3'b010), 32'h120, 32'h0000_2004, 32'h0,         32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 0, 4'h0,    32'h0,        32'h0000_2004);
    vecs[9]  = mkv(mk_ld(3'b000), 32'h124, 32'h0000_1000, 32'h0,         32'h80FF_FF7F, 1, 0, 32'h0000_007F, 0, 4'h0,    32'h0,        32'h0000_1000);
    vecs[10] = mkv(mk_st(3'b001), 32'h128, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000);
    vecs[11] = mkv(mk_st(3'b000), 32'h12C, 32'h0000_3001, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_3000);
    vecs[12] = mkv(mk_st(3'b010), 32'h130, 32'h0000_4000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 4'b1111, 32'hCAFE_F00D, 32'h0000_4000);

    // Table: each vector presented with dmem_ready in the first WAIT cycle.
    for (int i = 0; i < 13; i++) begin
      drive_ex(vecs[i].instr, vecs[i].pc, vecs[i].alu, vecs[i].op2);
      #1;
      chk($sformatf("v%0d_busy_issue", i), {31'h0, MA_busy}, {31'h0, vecs[i].mem});
      tick();
      if (vecs[i].mem) begin
        chk($sformatf("v%0d_req", i), {31'h0, dmem_req}, 32'h1);
        chk($sformatf("v%0d_we", i), {31'h0, dmem_we}, {31'h0, vecs[i].we});
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].addr);
        chk($sformatf("v%0d_wstrb", i), {28'h0, dmem_wstrb}, {28'h0, vecs[i].strb});
        if (vecs[i].we) chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
        dmem_ready = 1'b1;
        dmem_rdata = vecs[i].rdata;
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        chk($sformatf("v%0d_req_drop", i), {31'h0, dmem_req}, 32'h0);
        chk($sformatf("v%0d_busy_done", i), {31'h0, MA_busy}, 32'h0);
        tick();
      end else begin
        chk($sformatf("v%0d_no_req", i), {31'h0, dmem_req}, 32'h0);
      end
      chk($sformatf("v%0d_MA_PC", i), MA_PC, vecs[i].pc);
      chk($sformatf("v%0d_MA_instr", i), MA_instruction, vecs[i].instr);
      chk($sformatf("v%0d_MA_alu", i), MA_aluresult, vecs[i].alu);
      chk($sformatf("v%0d_MA_ld", i), MA_ldresult, vecs[i].ld);
      chk($sformatf("v%0d_MA_mis", i), {31'h0, MA_misaligned}, {31'h0, vecs[i].mis});
      chk($sformatf("v%0d_MA_berr", i), {31'h0, MA_bus_error}, 32'h0);
      chk($sformatf("v%0d_state_idle", i), {30'h0, ma_state}, 32'h0);
    end
    drive_ex(NOP, 32'h200, 32'h0, 32'h0);
    tick();

    // LB with dmem_ready arriving in the third WAIT cycle.
    drive_ex(mk_ld(3'b000), 32'h300, 32'h0000_1003, 32'h0);
    #1;
    busy_cnt = 0;
    wait_n   = 0;
    for (int c = 0; c < 5; c++) begin
      if (MA_busy) busy_cnt++;
      if (ma_state == 2'd1) begin
        dmem_ready = (wait_n == 2);
        dmem_rdata = (wait_n == 2) ? 32'h80FF_FF7F : 32'h0;
        wait_n++;
      end else begin
        dmem_ready = 1'b0;
      end
      tick();
    end
    dmem_ready = 1'b0;
    drive_ex(NOP, 32'h304, 32'h0, 32'h0);
    chk("late_busy_cycles", busy_cnt, 32'd4);
    chk("late_MA_ld", MA_ldresult, 32'hFFFF_FF80);
    chk("late_MA_PC", MA_PC, 32'h300);
    tick();

    // LW that never sees dmem_ready: aborted after 16 WAIT cycles.
    drive_ex(mk_ld(3'b010), 32'h400, 32'h0000_5000, 32'h0);
    tick();
    req_cnt = 0;
    while (dmem_req && req_cnt < 40) begin
      req_cnt++;
      tick();
    end
    chk("tmo_req_cycles", req_cnt, 32'd16);
    chk("tmo_state_done", {30'h0, ma_state}, 32'd2);
    tick();
    chk("tmo_MA_berr", {31'h0, MA_bus_error}, 32'h1);
    chk("tmo_MA_ld", MA_ldresult, 32'h0);
    chk("tmo_MA_alu", MA_aluresult, 32'h0000_5000);
    drive_ex(mk_addi(12'd7), 32'h404, 32'h0000_0007, 32'h0);
    tick();
    chk("tmo_berr_clear", {31'h0, MA_bus_error}, 32'h0);
    chk("tmo_next_alu", MA_aluresult, 32'h7);

    // Reset while an access is waiting.
    drive_ex(mk_ld(3'b010), 32'h500, 32'h0000_6000, 32'h0);
    repeat (3) tick();
    chk("rstw_req_before", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1;
    drive_ex(NOP, 32'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    chk("rstw_req", {31'h0, dmem_req}, 32'h0);
    chk("rstw_state", {30'h0, ma_state}, 32'h0);
    chk("rstw_MA_instr", MA_instruction, NOP);

    // Stall while holding a completed op in DONE, then in IDLE pass-through.
    drive_ex(mk_addi(12'd1), 32'h600, 32'h1, 32'h0);
    tick();
    prev_pc = MA_PC;
    drive_ex(mk_ld(3'b010), 32'h604, 32'h0000_7000, 32'h0);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ready = 1'b0;
    stall = 1'b1;
    #1;
    chk("stall_busy_done", {31'h0, MA_busy}, 32'h1);
    tick();
    chk("stall_hold_state", {30'h0, ma_state}, 32'd2);
    chk("stall_hold_PC", MA_PC, prev_pc);
    stall = 1'b0;
    tick();
    chk("stall_rel_PC", MA_PC, 32'h604);
    chk("stall_rel_ld", MA_ldresult, 32'h0BAD_F00D);
    drive_ex(mk_addi(12'd9), 32'h608, 32'h9, 32'h0);
    stall = 1'b1;
    #1;
    chk("stall_busy_idle", {31'h0, MA_busy}, 32'h1);
    tick();
    chk("stall_idle_hold", MA_aluresult, 32'h0000_7000);
    stall = 1'b0;
    tick();
    chk("stall_idle_rel", MA_aluresult, 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
